// File: rtl/uparb2_if.sv
// Request/acknowledge bus shared by both processor masters and the slave side of uparb2.
// The requester drives the strobe and transfer fields; the responder returns data and ack.
interface uparb2_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8
);
    logic              upen;
    logic              uprs;
    logic [ADDR_W-1:0] upa;
    logic [WIDTH-1:0]  updi;
    logic [WIDTH-1:0]  updo;
    logic              upack;

    modport master (output upen, uprs, upa, updi, input updo, upack);
    modport slave  (input upen, uprs, upa, updi, output updo, upack);
endinterface

// File: rtl/uparb2.sv
// Two-master round-robin arbiter onto a single processor bus with fully registered outputs.
// Define UPARB2_TIMEOUT_EN to bound the WAIT state and flag timeouts on to_err.
module uparb2 #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 8,
    parameter int TO_CYC = 15
) (
    input  logic     clk,
    input  logic     rst_n,
    uparb2_if.slave  m0,
    uparb2_if.slave  m1,
    uparb2_if.master bus,
    output logic     to_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              gnt_q, gnt_d;
    logic              upen_q, upen_d;
    logic              uprs_q, uprs_d;
    logic [ADDR_W-1:0] upa_q, upa_d;
    logic [WIDTH-1:0]  updi_q, updi_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [WIDTH-1:0]  m0_updo_q, m0_updo_d;
    logic [WIDTH-1:0]  m1_updo_q, m1_updo_d;
    logic              rsp_vld;
    logic [WIDTH-1:0]  rsp_data;
`ifdef UPARB2_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TO_CYC - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       to_err_q, to_err_d;
    logic       rsp_to;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave it unassigned (no latch).
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        upen_d    = 1'b0;
        uprs_d    = uprs_q;
        upa_d     = upa_q;
        updi_d    = updi_q;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m0_updo_d = m0_updo_q;
        m1_updo_d = m1_updo_q;
        rsp_vld   = 1'b0;
        rsp_data  = '0;
`ifdef UPARB2_TIMEOUT_EN
        cnt_d     = cnt_q;
        to_err_d  = 1'b0;
        rsp_to    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (m0.upen || m1.upen) begin
                    // The pointer only matters on a tie; a lone requester always wins.
                    gnt_d   = (m0.upen && m1.upen) ? ptr_q : m1.upen;
                    uprs_d  = gnt_d ? m1.uprs : m0.uprs;
                    upa_d   = gnt_d ? m1.upa  : m0.upa;
                    updi_d  = gnt_d ? m1.updi : m0.updi;
                    upen_d  = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef UPARB2_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: begin
                if (bus.upack) begin
                    rsp_vld  = 1'b1;
                    rsp_data = bus.updo;
                end
`ifdef UPARB2_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    rsp_vld  = 1'b1;
                    rsp_data = '1;
                    rsp_to   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (rsp_vld) begin
            state_d = DONE;
            ptr_d   = ~gnt_q;
            if (gnt_q) begin
                m1_ack_d  = 1'b1;
                m1_updo_d = rsp_data;
            end else begin
                m0_ack_d  = 1'b1;
                m0_updo_d = rsp_data;
            end
`ifdef UPARB2_TIMEOUT_EN
            to_err_d = rsp_to;
`endif
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every flop here is control or output state, so all of it is reset.
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            upen_q    <= 1'b0;
            uprs_q    <= 1'b0;
            upa_q     <= '0;
            updi_q    <= '0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            m0_updo_q <= '0;
            m1_updo_q <= '0;
`ifdef UPARB2_TIMEOUT_EN
            cnt_q     <= '0;
            to_err_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            upen_q    <= upen_d;
            uprs_q    <= uprs_d;
            upa_q     <= upa_d;
            updi_q    <= updi_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
            m0_updo_q <= m0_updo_d;
            m1_updo_q <= m1_updo_d;
`ifdef UPARB2_TIMEOUT_EN
            cnt_q     <= cnt_d;
            to_err_q  <= to_err_d;
`endif
        end
    end

    assign bus.upen  = upen_q;
    assign bus.uprs  = uprs_q;
    assign bus.upa   = upa_q;
    assign bus.updi  = updi_q;
    assign m0.upack  = m0_ack_q;
    assign m0.updo   = m0_updo_q;
    assign m1.upack  = m1_ack_q;
    assign m1.updo   = m1_updo_q;
`ifdef UPARB2_TIMEOUT_EN
    assign to_err    = to_err_q;
`else
    assign to_err    = 1'b0;
`endif
endmodule

// File: doc/uparb2.md
UPARB2 -- requirements
Module: uparb2

Interface
REQ-001 Parameter WIDTH, default 8: data width of the shared processor bus.
REQ-002 Parameter ADDR_W, default 8: address width of the shared processor bus.
REQ-003 Parameter TO_CYC, default 15: number of WAIT cycles before a timeout; legal range 1..255.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Ports m0_upen/m1_upen, input, 1 each: master request level, held high until the matching mN_upack.
REQ-007 Ports m0_uprs/m1_uprs, input, 1 each: 1 = read, 0 = write.
REQ-008 Ports m0_upa/m1_upa, input, ADDR_W each: request address.
REQ-009 Ports m0_updi/m1_updi, input, WIDTH each: write data.
REQ-010 Ports m0_updo/m1_updo, output, WIDTH each: read data, valid while mN_upack=1.
REQ-011 Ports m0_upack/m1_upack, output, 1 each: one-cycle completion pulse.
REQ-012 Ports upen/uprs, output, 1 each: shared-bus strobe and read/write select.
REQ-013 Port upa, output, ADDR_W: shared-bus address.
REQ-014 Port updi, output, WIDTH: shared-bus write data.
REQ-015 Port updo, input, WIDTH: read data from the slave macros (OR-combined upstream).
REQ-016 Port upack, input, 1: acknowledge from the slave.
REQ-017 Port to_err, output, 1: one-cycle pulse when a transaction times out.

Function
REQ-018 All outputs shall be registered; FSM states are IDLE, ISSUE, WAIT and DONE.
REQ-019 IDLE: if any mN_upen=1, the block shall grant one master, latch its uprs/upa/updi and go to ISSUE; otherwise it stays in IDLE.
REQ-020 Arbitration shall be round-robin via a 1-bit pointer naming the preferred master. When both masters request, the preferred master wins. The pointer moves to the other master after each completed or timed-out grant.
REQ-021 ISSUE: upen=1 for exactly one cycle with the latched uprs/upa/updi; then go to WAIT.
REQ-022 WAIT: upen=0 and upa/uprs/updi hold their latched values; on upack=1, capture updo and go to DONE.
REQ-023 DONE: the granted mN_upack=1 and mN_updo=captured data for one cycle; the other master's ack=0; then go to IDLE.
REQ-024 Latency: with a slave that acks one cycle after its strobe, a request sampled in IDLE in cycle 0 gives upen in cycle 1, upack in cycle 2 and mN_upack in cycle 3.
REQ-025 upack outside WAIT shall be ignored.
REQ-026 mN_updo shall hold its last value when not acked; the other master's updo is unchanged.
REQ-027 For a write (uprs=0), mN_updo shall equal updo captured at upack; the master ignores it.
REQ-028 A request deasserted before grant shall be dropped without bus activity.
REQ-029 The DONE state guarantees the acked master's held request is not re-granted; IDLE after DONE re-evaluates both requests fresh.

Reset
REQ-030 While rst_n=0, the block shall be in IDLE with the pointer at master 0. Outputs upen, uprs, upa, updi, mN_upack, mN_updo and to_err shall be 0, and the timeout counter 0.
REQ-031 A reset asserted mid-transaction shall abort it immediately, with no mN_upack; after release the block starts from IDLE.

Configuration
REQ-032 Macro UPARB2_TIMEOUT_EN, when defined, compiles in an 8-bit WAIT counter cleared on entry to WAIT.
REQ-033 With UPARB2_TIMEOUT_EN: if the counter reaches TO_CYC without upack, go to DONE with captured data = all ones and pulse to_err in the DONE cycle. upack arriving in the terminal cycle wins, with no to_err.
REQ-034 Without UPARB2_TIMEOUT_EN: WAIT lasts until upack (no bound); to_err is tied to 0; no counter logic exists.

Verification
REQ-035 m0 read, upa=0x12, slave returns 0xA5 one cycle after upen -> upen high in cycle 1 only, m0_upack in cycle 3 with m0_updo=0xA5, m1_upack=0.
REQ-036 m0 and m1 request in the same cycle after reset -> m0 served first, m1 granted at the next IDLE; a second simultaneous pair is served m0 then m1 again, following the pointer.
REQ-037 m1 write, upa=0x40, updi=0x3C -> upen=1, uprs=0, upa=0x40, updi=0x3C for one cycle; m1_upack after slave upack.
REQ-038 Spurious upack in IDLE/ISSUE, and rst_n pulsed low during WAIT -> upack ignored; on reset, all outputs 0 at once and no mN_upack.
REQ-039 UPARB2_TIMEOUT_EN, TO_CYC=15, slave never acks -> after 15 WAIT cycles, m0_upack=1 with m0_updo=0xFF and to_err=1 in the same cycle.
REQ-040 UPARB2_TIMEOUT_EN, upack in the terminal WAIT cycle with 0x5A -> m0_updo=0x5A, to_err=0.
